// File: rtl/qspi_mem_responder_if.sv
// Byte-wide request/ready memory port between the quad-SPI responder and its backing memory.
interface qspi_mem_responder_if #(
  parameter int unsigned PA = 24
);
  logic          mem_req;
  logic          mem_we;
  logic [PA-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ready;
  logic [7:0]    mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/qspi_mem_responder.sv
// Quad-SPI memory target: decodes 0xEB reads / 0x38 writes from the pins into byte requests
// on a req/ready memory port, with read prefetch and sticky underrun/overrun error.
module qspi_mem_responder #(
  parameter int unsigned PA    = 24,
  parameter int unsigned DUMMY = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_cs_n,
  input  logic                 spi_sck,
  input  logic [3:0]           spi_io_in,
  output logic [3:0]           spi_io_out,
  output logic [3:0]           spi_io_oe,
  output logic                 err,
  qspi_mem_responder_if.master mem
);

  localparam int unsigned AN = PA / 4;
  localparam int unsigned CW = $clog2(AN + DUMMY + 1);
  localparam logic [CW-1:0] A_LAST = CW'(AN - 1);
  localparam logic [CW-1:0] D_LAST = CW'((DUMMY == 0) ? 0 : DUMMY - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DUMMY  = 3'd3;
  localparam logic [2:0] S_RDATA  = 3'd4;
  localparam logic [2:0] S_WDATA  = 3'd5;
  localparam logic [2:0] S_IGNORE = 3'd6;

  // Pin synchronizers plus one delayed copy for edge detection
  logic [1:0] cs_s, sck_s;
  logic       cs_d, sck_d;
  logic [3:0] io_s0, io_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s  <= 2'b11;
      cs_d  <= 1'b1;
      sck_s <= 2'b00;
      sck_d <= 1'b0;
      io_s0 <= 4'h0;
      io_s1 <= 4'h0;
    end else begin
      cs_s  <= {cs_s[0], spi_cs_n};
      cs_d  <= cs_s[1];
      sck_s <= {sck_s[0], spi_sck};
      sck_d <= sck_s[1];
      io_s0 <= spi_io_in;
      io_s1 <= io_s0;
    end
  end

  logic sck_rise_c, sck_fall_c, cs_hi_c, cs_fall_c, pending_c;
  assign sck_rise_c = sck_s[1] & ~sck_d;
  assign sck_fall_c = ~sck_s[1] & sck_d;
  assign cs_hi_c    = cs_s[1];
  assign cs_fall_c  = cs_d & ~cs_s[1];

  logic [2:0]    state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [PA-5:0] sh_q, sh_n;
  logic          rd_q, rd_n;
  logic [PA-1:0] addr_q, addr_n;
  logic          req_q, req_n;
  logic          we_q, we_n;
  logic [PA-1:0] maddr_q, maddr_n;
  logic [7:0]    wdata_q, wdata_n;
  logic          err_q, err_n;
  logic [3:0]    io_q, io_n;
  logic          oe_q, oe_n;
  logic [7:0]    rbuf_q, rbuf_n;
  logic          rvalid_q, rvalid_n;
  logic          low_q, low_n;
  logic [3:0]    lnib_q, lnib_n;
  logic [3:0]    whi_q, whi_n;
  logic          wph_q, wph_n;
  logic          drop_q, drop_n;
  logic [PA-1:0] sh_next, addr_inc;

  // A request is still outstanding if it is not being accepted this cycle
  assign pending_c = req_q & ~mem.mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      wdata_q  <= 8'h00;
      err_q    <= 1'b0;
      io_q     <= 4'h0;
      oe_q     <= 1'b0;
      rbuf_q   <= 8'h00;
      rvalid_q <= 1'b0;
      low_q    <= 1'b0;
      lnib_q   <= 4'h0;
      whi_q    <= 4'h0;
      wph_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      sh_q     <= sh_n;
      rd_q     <= rd_n;
      addr_q   <= addr_n;
      req_q    <= req_n;
      we_q     <= we_n;
      maddr_q  <= maddr_n;
      wdata_q  <= wdata_n;
      err_q    <= err_n;
      io_q     <= io_n;
      oe_q     <= oe_n;
      rbuf_q   <= rbuf_n;
      rvalid_q <= rvalid_n;
      low_q    <= low_n;
      lnib_q   <= lnib_n;
      whi_q    <= whi_n;
      wph_q    <= wph_n;
      drop_q   <= drop_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    sh_n     = sh_q;
    rd_n     = rd_q;
    addr_n   = addr_q;
    req_n    = req_q & ~mem.mem_ready;
    we_n     = we_q;
    maddr_n  = maddr_q;
    wdata_n  = wdata_q;
    err_n    = err_q;
    io_n     = io_q;
    oe_n     = oe_q;
    rbuf_n   = rbuf_q;
    rvalid_n = rvalid_q;
    low_n    = low_q;
    lnib_n   = lnib_q;
    whi_n    = whi_q;
    wph_n    = wph_q;
    drop_n   = drop_q;
    sh_next  = {sh_q, io_s1};
    addr_inc = addr_q + PA'(1);

    // Read data capture; data belonging to an abandoned request is discarded
    if (req_q && mem.mem_ready) begin
      drop_n = 1'b0;
      if (!we_q && !drop_q) begin
        rbuf_n   = mem.mem_rdata;
        rvalid_n = 1'b1;
      end
    end

    if (state_q != S_IDLE && cs_hi_c) begin
      state_n = S_IDLE;
      oe_n    = 1'b0;
      if (pending_c && !we_q) drop_n = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          oe_n = 1'b0;
          if (cs_fall_c) begin
            state_n  = S_CMD;
            cnt_n    = '0;
            err_n    = 1'b0;
            wph_n    = 1'b0;
            low_n    = 1'b0;
            rvalid_n = 1'b0;
          end
        end
        S_CMD: begin
          if (sck_rise_c) begin
            sh_n = sh_next[PA-5:0];
            if (cnt_q == CW'(1)) begin
              cnt_n = '0;
              if (sh_next[7:0] == 8'hEB) begin
                rd_n    = 1'b1;
                state_n = S_ADDR;
              end else if (sh_next[7:0] == 8'h38) begin
                rd_n    = 1'b0;
                state_n = S_ADDR;
              end else begin
                state_n = S_IGNORE;
              end
            end else begin
              cnt_n = cnt_q + CW'(1);
            end
          end
        end
        S_ADDR: begin
          if (sck_rise_c) begin
            sh_n = sh_next[PA-5:0];
            if (cnt_q == A_LAST) begin
              cnt_n  = '0;
              addr_n = sh_next;
              if (rd_q) begin
                if (!pending_c) begin
                  req_n   = 1'b1;
                  we_n    = 1'b0;
                  maddr_n = sh_next;
                end
                rvalid_n = 1'b0;
                low_n    = 1'b0;
                state_n  = (DUMMY == 0) ? S_RDATA : S_DUMMY;
              end else begin
                wph_n   = 1'b0;
                state_n = S_WDATA;
              end
            end else begin
              cnt_n = cnt_q + CW'(1);
            end
          end
        end
        S_DUMMY: begin
          oe_n = 1'b0;
          if (sck_rise_c) begin
            if (cnt_q == D_LAST) begin
              cnt_n   = '0;
              state_n = S_RDATA;
            end else begin
              cnt_n = cnt_q + CW'(1);
            end
          end
        end
        S_RDATA: begin
          // High nibble slot: serve the byte (or 0xFF on underrun) and prefetch the next address
          if (sck_fall_c) begin
            oe_n = 1'b1;
            if (!low_q) begin
              low_n  = 1'b1;
              addr_n = addr_inc;
              if (rvalid_q) begin
                io_n   = rbuf_q[7:4];
                lnib_n = rbuf_q[3:0];
              end else begin
                io_n   = 4'hF;
                lnib_n = 4'hF;
                err_n  = 1'b1;
              end
              rvalid_n = 1'b0;
              if (pending_c) begin
                drop_n = 1'b1;
              end else begin
                req_n   = 1'b1;
                we_n    = 1'b0;
                maddr_n = addr_inc;
              end
            end else begin
              io_n  = lnib_q;
              low_n = 1'b0;
            end
          end
        end
        S_WDATA: begin
          if (sck_rise_c) begin
            if (!wph_q) begin
              whi_n = io_s1;
              wph_n = 1'b1;
            end else begin
              wph_n  = 1'b0;
              addr_n = addr_inc;
              if (pending_c) begin
                err_n = 1'b1;
              end else begin
                req_n   = 1'b1;
                we_n    = 1'b1;
                maddr_n = addr_q;
                wdata_n = {whi_q, io_s1};
              end
            end
          end
        end
        S_IGNORE: oe_n = 1'b0;
        default:  state_n = S_IDLE;
      endcase
    end
  end

  assign spi_io_out    = io_q;
  assign spi_io_oe     = {4{oe_q}};
  assign err           = err_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Bench for qspi_mem_responder: drives quad-SPI transactions as the CPU would and checks the
// memory requests and returned nibbles against a simple memory-image model.
module tb_qspi_mem_responder;

  localparam int unsigned PA    = 24;
  localparam int unsigned DUMMY = 4;
  localparam int          HALF  = 6;

  logic       clk = 1'b0;
  logic       rst_n, cs_n, sck;
  logic [3:0] io_in, io_out, io_oe;
  logic       err;

  qspi_mem_responder_if #(.PA(PA)) mem_bus ();

  qspi_mem_responder #(.PA(PA), .DUMMY(DUMMY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_cs_n  (cs_n),
    .spi_sck   (sck),
    .spi_io_in (io_in),
    .spi_io_out(io_out),
    .spi_io_oe (io_oe),
    .err       (err),
    .mem       (mem_bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [7:0]  data;
  } req_t;

  req_t       log_q[$];
  logic [7:0] mem_img [logic [23:0]];
  logic [3:0] got_nib[$];
  logic [7:0] wbytes[$];
  int lat = 0;
  int wcnt = 0;
  int oe_bad_ctrl, oe_bad_data;
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  // Memory with programmable wait states; logs every accepted request
  always @(negedge clk) begin
    if (mem_bus.mem_req) begin
      if (wcnt >= lat) begin
        mem_bus.mem_ready = 1'b1;
        wcnt = 0;
        if (mem_bus.mem_we) begin
          mem_img[mem_bus.mem_addr] = mem_bus.mem_wdata;
          log_q.push_back({1'b1, mem_bus.mem_addr, mem_bus.mem_wdata});
        end else begin
          mem_bus.mem_rdata = mem_rd(mem_bus.mem_addr);
          log_q.push_back({1'b0, mem_bus.mem_addr, mem_bus.mem_rdata});
        end
      end else begin
        mem_bus.mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      mem_bus.mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One SCK period: low phase with data set up, sample, rising edge, high phase
  task automatic cyc(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] doe);
    sck   = 1'b0;
    io_in = din;
    wclk(HALF);
    dout = io_out;
    doe  = io_oe;
    sck  = 1'b1;
    wclk(HALF);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [3:0] d, o;
    cyc(cmd[7:4], d, o); if (o !== 4'h0) oe_bad_ctrl++;
    cyc(cmd[3:0], d, o); if (o !== 4'h0) oe_bad_ctrl++;
    for (int i = 5; i >= 0; i--) begin
      cyc(a[i*4 +: 4], d, o);
      if (o !== 4'h0) oe_bad_ctrl++;
    end
  endtask

  task automatic start_txn(input logic [7:0] cmd, input logic [23:0] a);
    oe_bad_ctrl = 0;
    oe_bad_data = 0;
    log_q.delete();
    got_nib.delete();
    cs_n = 1'b0;
    wclk(HALF);
    send_hdr(cmd, a);
  endtask

  task automatic stop_txn();
    cs_n = 1'b1;
    wclk(HALF);
    sck = 1'b0;
    wclk(3 * HALF);
  endtask

  task automatic run_read(input logic [23:0] a, input int n);
    logic [3:0] d, o;
    start_txn(8'hEB, a);
    for (int i = 0; i < int'(DUMMY); i++) begin
      cyc(4'(i), d, o);
      if (o !== 4'h0) oe_bad_ctrl++;
    end
    for (int i = 0; i < 2 * n; i++) begin
      cyc(4'h0, d, o);
      got_nib.push_back(d);
      if (o !== 4'hF) oe_bad_data++;
    end
    stop_txn();
  endtask

  task automatic run_write(input logic [23:0] a, input int n);
    logic [3:0] d, o;
    start_txn(8'h38, a);
    for (int i = 0; i < n; i++) begin
      cyc(wbytes[i][7:4], d, o); if (o !== 4'h0) oe_bad_ctrl++;
      cyc(wbytes[i][3:0], d, o); if (o !== 4'h0) oe_bad_ctrl++;
    end
    stop_txn();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs_n = 1'b1; sck = 1'b0; io_in = 4'h0;
    wclk(4);
    n_checks++;
    if ({io_out, io_oe, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: out=%h oe=%h req=%b we=%b addr=%h wdata=%h err=%b, expected all zero",
               io_out, io_oe, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, err);
    end
    rst_n = 1'b1;
    wclk(4);
    n_checks++;
    if ({io_oe, mem_bus.mem_req, err} !== '0) begin
      n_fail++;
      $display("FAIL after_reset_idle: oe=%h req=%b err=%b, expected 0", io_oe, mem_bus.mem_req, err);
    end
  endtask

  task automatic test_read_basic();
    logic [3:0] exp_n[4] = '{4'hA, 4'h5, 4'h3, 4'hC};
    mem_img[24'h000100] = 8'hA5;
    mem_img[24'h000101] = 8'h3C;
    lat = 0;
    run_read(24'h000100, 2);
    n_checks++;
    if (got_nib.size() != 4) begin
      n_fail++; $display("FAIL read_basic_len: got %0d nibbles, expected 4", got_nib.size());
    end
    for (int i = 0; i < 4 && i < got_nib.size(); i++) begin
      n_checks++;
      if (got_nib[i] !== exp_n[i]) begin
        n_fail++; $display("FAIL read_basic_nib%0d: got %h expected %h", i, got_nib[i], exp_n[i]);
      end
    end
    n_checks++;
    if (log_q.size() != 3) begin
      n_fail++; $display("FAIL read_basic_nreq: got %0d requests, expected 3", log_q.size());
    end
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i].we !== 1'b0 || log_q[i].addr !== 24'h000100 + 24'(i)) begin
        n_fail++; $display("FAIL read_basic_req%0d: got we=%b addr=%h expected we=0 addr=%h",
                           i, log_q[i].we, log_q[i].addr, 24'h000100 + 24'(i));
      end
    end
    n_checks++;
    if (err !== 1'b0 || oe_bad_ctrl != 0 || oe_bad_data != 0) begin
      n_fail++; $display("FAIL read_basic_flags: err=%b oe_bad_ctrl=%0d oe_bad_data=%0d expected 0/0/0",
                         err, oe_bad_ctrl, oe_bad_data);
    end
  endtask

  task automatic test_write_basic();
    req_t exp_r[2];
    exp_r[0] = {1'b1, 24'h0000FF, 8'h12};
    exp_r[1] = {1'b1, 24'h000100, 8'h34};
    wbytes = '{8'h12, 8'h34};
    lat = 0;
    run_write(24'h0000FF, 2);
    n_checks++;
    if (log_q.size() != 2) begin
      n_fail++; $display("FAIL write_basic_nreq: got %0d requests, expected 2", log_q.size());
    end
    for (int i = 0; i < 2 && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i] !== exp_r[i]) begin
        n_fail++; $display("FAIL write_basic_req%0d: got %h expected %h", i, log_q[i], exp_r[i]);
      end
    end
    n_checks++;
    if (oe_bad_ctrl != 0 || err !== 1'b0) begin
      n_fail++; $display("FAIL write_basic_oe: oe driven in %0d cycles err=%b, expected 0/0", oe_bad_ctrl, err);
    end
  endtask

  task automatic test_wrap();
    lat = 1;
    run_read(24'hFFFFFF, 2);
    n_checks++;
    if (log_q.size() < 2 || log_q[0].addr !== 24'hFFFFFF || log_q[1].addr !== 24'h000000) begin
      n_fail++;
      $display("FAIL wrap_addr: got %0d requests first=%h second=%h expected FFFFFF then 000000",
               log_q.size(), (log_q.size() > 0) ? log_q[0].addr : 24'hx, (log_q.size() > 1) ? log_q[1].addr : 24'hx);
    end
    n_checks++;
    if (got_nib.size() != 4 || got_nib[2] !== mem_rd(24'h000000) >> 4) begin
      n_fail++; $display("FAIL wrap_data: got %0d nibbles, byte1 high nibble %h expected %h",
                         got_nib.size(), (got_nib.size() > 2) ? got_nib[2] : 4'hx, mem_rd(24'h000000) >> 4);
    end
  endtask

  task automatic test_underrun();
    int guard = 0;
    lat = 200;
    run_read(24'h000200, 1);
    n_checks++;
    if (got_nib.size() != 2 || got_nib[0] !== 4'hF || got_nib[1] !== 4'hF) begin
      n_fail++; $display("FAIL underrun_nibs: got %0d nibbles %h %h expected F F", got_nib.size(),
                         (got_nib.size() > 0) ? got_nib[0] : 4'hx, (got_nib.size() > 1) ? got_nib[1] : 4'hx);
    end
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL underrun_err: err=%b expected 1", err);
    end
    while (mem_bus.mem_req && guard < 1000) begin
      wclk(1);
      guard++;
    end
    n_checks++;
    if (guard >= 1000 || err !== 1'b1) begin
      n_fail++; $display("FAIL underrun_drain: req still %b after %0d cycles, err=%b expected req 0 err 1",
                         mem_bus.mem_req, guard, err);
    end
    lat = 0;
    wbytes = '{8'h9E};
    log_q.delete();
    cs_n = 1'b0;
    wclk(HALF);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: err=%b expected 0 after cs_n fall", err);
    end
    send_hdr(8'h38, 24'h000300);
    begin
      logic [3:0] d, o;
      cyc(4'h9, d, o);
      cyc(4'hE, d, o);
    end
    stop_txn();
    n_checks++;
    if (log_q.size() != 1 || log_q[0] !== {1'b1, 24'h000300, 8'h9E}) begin
      n_fail++; $display("FAIL err_clear_write: got %0d requests first=%h expected 1 request %h",
                         log_q.size(), (log_q.size() > 0) ? log_q[0] : 33'hx, {1'b1, 24'h000300, 8'h9E});
    end
  endtask

  task automatic test_ignore();
    logic [3:0] d, o;
    lat = 0;
    start_txn(8'h05, 24'($urandom));
    for (int i = 0; i < 8; i++) begin
      cyc(4'($urandom), d, o);
      if (o !== 4'h0) oe_bad_ctrl++;
    end
    stop_txn();
    n_checks++;
    if (log_q.size() != 0 || oe_bad_ctrl != 0 || err !== 1'b0) begin
      n_fail++; $display("FAIL ignore_cmd: requests=%0d oe_cycles=%0d err=%b expected 0/0/0",
                         log_q.size(), oe_bad_ctrl, err);
    end
  endtask

  task automatic test_random();
    logic [23:0] a;
    logic [7:0]  eb[5];
    int n;
    for (int k = 0; k < 8; k++) begin
      a   = 24'($urandom);
      n   = int'($urandom_range(1, 4));
      lat = int'($urandom_range(0, 3));
      if (k % 2 == 0) begin
        for (int i = 0; i <= n; i++) begin
          eb[i] = 8'($urandom);
          mem_img[24'(a + 24'(i))] = eb[i];
        end
        run_read(a, n);
        n_checks++;
        if (got_nib.size() != 2 * n || log_q.size() != n + 1 || err !== 1'b0 || oe_bad_data != 0 || oe_bad_ctrl != 0) begin
          n_fail++; $display("FAIL rand_read%0d_shape: nibbles=%0d reqs=%0d err=%b oe_bad=%0d/%0d expected %0d/%0d/0/0/0",
                             k, got_nib.size(), log_q.size(), err, oe_bad_ctrl, oe_bad_data, 2 * n, n + 1);
        end
        for (int i = 0; i < 2 * n && i < got_nib.size(); i++) begin
          n_checks++;
          if (got_nib[i] !== ((i % 2 == 0) ? eb[i/2][7:4] : eb[i/2][3:0])) begin
            n_fail++; $display("FAIL rand_read%0d_nib%0d: got %h expected %h", k, i, got_nib[i],
                               (i % 2 == 0) ? eb[i/2][7:4] : eb[i/2][3:0]);
          end
        end
        for (int i = 0; i <= n && i < log_q.size(); i++) begin
          n_checks++;
          if (log_q[i].we !== 1'b0 || log_q[i].addr !== 24'(a + 24'(i))) begin
            n_fail++; $display("FAIL rand_read%0d_req%0d: got we=%b addr=%h expected we=0 addr=%h",
                               k, i, log_q[i].we, log_q[i].addr, 24'(a + 24'(i)));
          end
        end
      end else begin
        wbytes.delete();
        for (int i = 0; i < n; i++) wbytes.push_back(8'($urandom));
        run_write(a, n);
        n_checks++;
        if (log_q.size() != n || err !== 1'b0 || oe_bad_ctrl != 0) begin
          n_fail++; $display("FAIL rand_write%0d_shape: reqs=%0d err=%b oe_cycles=%0d expected %0d/0/0",
                             k, log_q.size(), err, oe_bad_ctrl, n);
        end
        for (int i = 0; i < n && i < log_q.size(); i++) begin
          n_checks++;
          if (log_q[i] !== {1'b1, 24'(a + 24'(i)), wbytes[i]}) begin
            n_fail++; $display("FAIL rand_write%0d_req%0d: got %h expected %h", k, i, log_q[i],
                               {1'b1, 24'(a + 24'(i)), wbytes[i]});
          end
        end
      end
    end
  endtask

  task automatic test_abort_and_reset();
    logic [3:0] d, o;
    lat = 0;
    start_txn(8'h38, 24'h000400);
    cyc(4'h7, d, o);
    stop_txn();
    wclk(10);
    n_checks++;
    if (log_q.size() != 0) begin
      n_fail++; $display("FAIL abort_write: got %0d requests expected 0", log_q.size());
    end
    mem_img[24'h000100] = 8'hA5;
    start_txn(8'hEB, 24'h000100);
    for (int i = 0; i < int'(DUMMY); i++) cyc(4'h0, d, o);
    cyc(4'h0, d, o);
    sck = 1'b0;
    wclk(HALF);
    n_checks++;
    if (d !== 4'hA || io_oe !== 4'hF || io_out !== 4'h5) begin
      n_fail++; $display("FAIL midread_state: first nib %h oe=%h out=%h expected A F 5", d, io_oe, io_out);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({io_out, io_oe, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, err} !== '0) begin
      n_fail++;
      $display("FAIL midread_reset: out=%h oe=%h req=%b we=%b addr=%h wdata=%h err=%b expected all zero",
               io_out, io_oe, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, err);
    end
    cs_n = 1'b1;
    wclk(4);
    rst_n = 1'b1;
    wclk(6);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_wrap();
    test_underrun();
    test_ignore();
    test_random();
    test_abort_and_reset();
    test_read_basic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
